sobel_write_sequencer: RTL
==========================

// Module: sobel_write_sequencer
// PURPOSE
//  Raster-order write sequencer between the Sobel filter pixel stream and the BMP frame writer.
//  Accepts pixels over a valid/ready handshake and stamps each pixel with row/col indices.
//  Drives the writer's write strobe, then waits for the writer's done pulse.
//  Reports frame completion, or a timeout error, to the top-level frame controller.
// PARAMETERS
//  WIDTH           768   pixels per row
//  HEIGHT          512   rows per frame
//  BITS_FOR_INDEX  10    row/col index width, ceil(lg(max(WIDTH,HEIGHT)))
//  PIX_W           8     bits per colour channel
//  DONE_TIMEOUT    1024  max cycles in WAIT_DONE before error (>=2)
// PORTS
//  HCLK            in   1       clock
//  HRESETn         in   1       reset, asynchronous, active-low
//  start           in   1       1-cycle pulse: begin a frame (honoured in IDLE only)
//  abort           in   1       synchronous abort, any state
//  pix_valid       in   1       filter pixel valid
//  pix_ready       out  1       sequencer accepts pixel this cycle
//  pix_r/g/b       in   PIX_W   filter pixel channels
//  rowIndex        out  BITS_FOR_INDEX  row of the pixel being written
//  colIndex        out  BITS_FOR_INDEX  column of the pixel being written
//  DATA_WRITE_R0/G0/B0 out PIX_W  registered pixel to writer
//  writeBackImage  out  1       write strobe to writer, 1 cycle per pixel
//  Write_Done      in   1       writer finished-file pulse
//  busy            out  1       state != IDLE
//  frame_done      out  1       1-cycle pulse on successful frame
//  timeout_err     out  1       sticky; cleared by next accepted start or reset
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; counters 0; timeout_err=0.
//  States: IDLE -> RUN -> WAIT_DONE -> DONE -> IDLE.
//  IDLE: pix_ready=0. start=1 & abort=0 -> RUN; row/col counters=0; timeout_err cleared.
//  RUN: pix_ready=1.
//   - Pixel accepted when pix_valid & pix_ready.
//   - On accept, next cycle: writeBackImage=1; DATA_* = pixel;
//     rowIndex/colIndex = counter values at accept.
//   - Latency: exactly 1 cycle, input to strobe. No accept -> writeBackImage=0 next cycle;
//     DATA_* and indices hold their last values.
//   - Counter advance: col++; at col==WIDTH-1, col wraps to 0 and row++.
//   - Accept at row==HEIGHT-1, col==WIDTH-1 -> WAIT_DONE. pix_ready=0 from the next cycle;
//     the final strobe still issues.
//  WAIT_DONE: pix_ready=0; timer counts up from 0.
//   - Write_Done=1 -> DONE.
//   - timer==DONE_TIMEOUT-1 without Write_Done -> timeout_err=1, IDLE.
//  DONE: frame_done=1 for 1 cycle -> IDLE.
//  Write_Done seen outside WAIT_DONE: ignored.
//  start while busy: ignored.
//  abort:
//   - Next state IDLE; counters/timer cleared; pix_ready=0.
//   - Any strobe already registered still issues.
//   - frame_done not pulsed; timeout_err unchanged.
//   - abort and start in the same cycle: abort wins.
//  Write_Done and timeout in the same cycle: Write_Done wins (DONE, no error).
//  HRESETn low mid-frame: immediate return to reset values; no partial-frame done.
//  Width rules: counters are BITS_FOR_INDEX bits and never exceed WIDTH-1 / HEIGHT-1.
//   Timer width is clog2(DONE_TIMEOUT).
// STRUCTURE
//  Shared package (img_pkg): state encoding localparams (IDLE=0, RUN=1, WAIT_DONE=2, DONE=3);
//   default WIDTH/HEIGHT/BITS_FOR_INDEX/PIX_W.
//  Sub-module raster_counter: clr, en -> col, row, last (row==HEIGHT-1 & col==WIDTH-1).
//  Top level: FSM, 1-stage output register, timeout timer.
// TESTING
//  1. WIDTH=4, HEIGHT=3; start; pix_valid=1 with 12 pixels ->
//     12 strobes, indices (0,0)..(2,3) in order; pix_ready=0 after the 12th;
//     Write_Done 5 cycles later -> frame_done pulse; busy=0 the cycle after.
//  2. Random pix_valid gaps (50%) -> strobe only the cycle after each accept;
//     row/col wrap 3->0 with row+1; DATA_* match input order.
//  3. DONE_TIMEOUT=8; no Write_Done -> timeout_err=1 exactly 8 cycles after entering
//     WAIT_DONE; state IDLE; next start clears timeout_err.
//  4. abort at pixel 5 -> pix_ready=0 next cycle; no frame_done.
//     New start then restarts indices at (0,0).
//  5. start+abort same cycle in IDLE -> stays IDLE.
//     start during RUN -> no effect on counters.
//  6. HRESETn low mid-RUN -> all outputs 0 asynchronously.
//     Write_Done pulse in IDLE -> frame_done stays 0.

Source files
------------

// File: rtl/img_pkg.sv
// Shared image-pipeline definitions: frame geometry defaults and the
// write-sequencer state encoding.
package img_pkg;

  localparam int IMG_WIDTH          = 768;
  localparam int IMG_HEIGHT         = 512;
  localparam int IMG_BITS_FOR_INDEX = 10;
  localparam int IMG_PIX_W          = 8;
  localparam int IMG_DONE_TIMEOUT   = 1024;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    WAIT_DONE = 2'd2,
    DONE      = 2'd3
  } seq_state_t;

endpackage

// File: rtl/raster_counter.sv
// Raster-order column/row counter. Column advances on each enable and wraps
// into the next row; the row wraps back to 0 after the last row.
module raster_counter
  import img_pkg::*;
#(
  parameter int WIDTH          = IMG_WIDTH,
  parameter int HEIGHT         = IMG_HEIGHT,
  parameter int BITS_FOR_INDEX = IMG_BITS_FOR_INDEX
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      clr,
  input  logic                      en,
  output logic [BITS_FOR_INDEX-1:0] col,
  output logic [BITS_FOR_INDEX-1:0] row,
  output logic                      last
);

  logic col_end_s;
  logic row_end_s;

  // End-of-row / end-of-frame detection from the current position.
  always_comb begin
    col_end_s = (col == BITS_FOR_INDEX'(WIDTH - 1));
    row_end_s = (row == BITS_FOR_INDEX'(HEIGHT - 1));
    last      = col_end_s & row_end_s;
  end

  // Position register: clear has priority over advance.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      col <= {BITS_FOR_INDEX{1'b0}};
      row <= {BITS_FOR_INDEX{1'b0}};
    end else if (clr) begin
      col <= {BITS_FOR_INDEX{1'b0}};
      row <= {BITS_FOR_INDEX{1'b0}};
    end else if (en) begin
      if (col_end_s) begin
        col <= {BITS_FOR_INDEX{1'b0}};
        row <= row_end_s ? {BITS_FOR_INDEX{1'b0}} : row + BITS_FOR_INDEX'(1);
      end else begin
        col <= col + BITS_FOR_INDEX'(1);
      end
    end
  end

endmodule

// File: rtl/sobel_write_sequencer.sv
// Raster-order write sequencer between the Sobel pixel stream and the BMP
// frame writer. Stamps each accepted pixel with row/col, strobes the writer
// one cycle later, then waits (bounded) for the writer's done pulse.
module sobel_write_sequencer
  import img_pkg::*;
#(
  parameter int WIDTH          = IMG_WIDTH,
  parameter int HEIGHT         = IMG_HEIGHT,
  parameter int BITS_FOR_INDEX = IMG_BITS_FOR_INDEX,
  parameter int PIX_W          = IMG_PIX_W,
  parameter int DONE_TIMEOUT   = IMG_DONE_TIMEOUT
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      pix_valid,
  output logic                      pix_ready,
  input  logic [PIX_W-1:0]          pix_r,
  input  logic [PIX_W-1:0]          pix_g,
  input  logic [PIX_W-1:0]          pix_b,
  output logic [BITS_FOR_INDEX-1:0] rowIndex,
  output logic [BITS_FOR_INDEX-1:0] colIndex,
  output logic [PIX_W-1:0]          DATA_WRITE_R0,
  output logic [PIX_W-1:0]          DATA_WRITE_G0,
  output logic [PIX_W-1:0]          DATA_WRITE_B0,
  output logic                      writeBackImage,
  input  logic                      Write_Done,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      timeout_err
);

  localparam int TMR_W = (DONE_TIMEOUT > 2) ? $clog2(DONE_TIMEOUT) : 1;

  seq_state_t                state_r;
  seq_state_t                state_n;
  logic [TMR_W-1:0]          timer_r;
  logic [BITS_FOR_INDEX-1:0] col_s;
  logic [BITS_FOR_INDEX-1:0] row_s;
  logic                      last_s;
  logic                      accept_s;
  logic                      start_ok_s;
  logic                      timeout_s;
  logic                      clr_s;

  raster_counter #(
    .WIDTH          (WIDTH),
    .HEIGHT         (HEIGHT),
    .BITS_FOR_INDEX (BITS_FOR_INDEX)
  ) u_raster (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .clr     (clr_s),
    .en      (accept_s),
    .col     (col_s),
    .row     (row_s),
    .last    (last_s)
  );

  // Handshake, start qualification and timeout detection.
  // pix_ready is a registered copy of (state == RUN), so it doubles as the run gate.
  always_comb begin
    accept_s   = pix_valid & pix_ready;
    start_ok_s = (state_r == IDLE) & start & ~abort;
    timeout_s  = (state_r == WAIT_DONE) & ~Write_Done &
                 (timer_r == TMR_W'(DONE_TIMEOUT - 1));
    clr_s      = abort | start_ok_s;
  end

  // Next-state logic; abort overrides every state, Write_Done beats timeout.
  always_comb begin
    state_n = state_r;
    if (abort) begin
      state_n = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_n = RUN;
          end else begin
            state_n = IDLE;
          end
        end
        RUN: begin
          if (accept_s && last_s) begin
            state_n = WAIT_DONE;
          end else begin
            state_n = RUN;
          end
        end
        WAIT_DONE: begin
          if (Write_Done) begin
            state_n = DONE;
          end else if (timeout_s) begin
            state_n = IDLE;
          end else begin
            state_n = WAIT_DONE;
          end
        end
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // State, wait timer and registered status outputs.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r     <= IDLE;
      timer_r     <= {TMR_W{1'b0}};
      pix_ready   <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_r    <= state_n;
      timer_r    <= ((state_r == WAIT_DONE) && (state_n == WAIT_DONE)) ?
                    timer_r + TMR_W'(1) : {TMR_W{1'b0}};
      pix_ready  <= (state_n == RUN);
      busy       <= (state_n != IDLE);
      frame_done <= (state_n == DONE);
      if (start_ok_s) begin
        timeout_err <= 1'b0;
      end else if (timeout_s && !abort) begin
        timeout_err <= 1'b1;
      end
    end
  end

  // One-stage output register: strobe follows each accept; data/indices hold otherwise.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      writeBackImage <= 1'b0;
      rowIndex       <= {BITS_FOR_INDEX{1'b0}};
      colIndex       <= {BITS_FOR_INDEX{1'b0}};
      DATA_WRITE_R0  <= {PIX_W{1'b0}};
      DATA_WRITE_G0  <= {PIX_W{1'b0}};
      DATA_WRITE_B0  <= {PIX_W{1'b0}};
    end else begin
      writeBackImage <= accept_s;
      if (accept_s) begin
        rowIndex      <= row_s;
        colIndex      <= col_s;
        DATA_WRITE_R0 <= pix_r;
        DATA_WRITE_G0 <= pix_g;
        DATA_WRITE_B0 <= pix_b;
      end
    end
  end

endmodule
